audio_serial_tx: RTL and testbench
==================================

// Module: audio_serial_tx
// PURPOSE
//  Consumer end of the simulated audio sample stream: accepts signed PCM samples over a valid/ready
//  handshake, buffers them in a small FIFO and serializes them as a stereo bit-serial DAC stream.
//  Output format is left-justified by default, or I2S when the optional feature is enabled.
//  The stream is interleaved: even samples go to the left slot, odd samples to the right slot.
//  Sits between the sample source (file-driven in benches) and the DAC pins.
// PARAMETERS
//  WIDTH     32  sample width in bits; slot length in bit periods
//  DEPTH     4   FIFO depth in samples; power of 2, >=2
//  BCLK_DIV  4   clock cycles per serial bit period; even, >=2
// PORTS
//  clock      in   1      system clock, all logic on posedge
//  reset_n    in   1      asynchronous active-low reset
//  enable     in   1      1 = serializer runs; 0 = serializer idle, FIFO still accepts
//  audio      in   WIDTH  signed sample, two's complement
//  valid      in   1      audio is valid this cycle
//  ready      out  1      FIFO can accept; equals !full
//  bclk       out  1      serial bit clock
//  lrclk      out  1      word select; 0 = left slot, 1 = right slot
//  sdata      out  1      serial data, MSB first
//  underrun   out  1      sticky; set when a slot starts with the FIFO empty
//  clear      in   1      synchronous clear of underrun
// BEHAVIOUR
//  Reset: FIFO empty, ready=1, bclk=0, lrclk=0, sdata=0, underrun=0, all counters 0.
//  Push: on a clock with valid && ready, audio is written to the FIFO tail. No bypass path.
//  Pop: occurs only at a slot start. Push and pop in the same cycle leave the count unchanged.
//  Push when full is impossible because ready=0.
//  Counters:
//   - div counter runs 0..BCLK_DIV-1.
//   - bit counter runs 0..WIDTH-1.
//   - slot bit (lrclk) toggles each time the bit counter wraps.
//  bclk is 0 for div 0..BCLK_DIV/2-1 and 1 for the rest of the bit period.
//  sdata and lrclk change only on the clock edge where div wraps to 0, i.e. at the bclk falling edge.
//  Slot start (div=0, bit=0):
//   - If the FIFO is non-empty: pop the head into the shift register.
//   - If the FIFO is empty: load 0 and set underrun.
//  Bit b of a slot drives shift[WIDTH-1-b] (MSB first).
//  Frame timing: one frame = 2*WIDTH*BCLK_DIV clocks; it starts with lrclk=0.
//  Latency: a sample pushed into an empty FIFO while idle appears on sdata starting at the next slot start.
//  enable=0:
//   - Counters are held at 0; bclk, lrclk and sdata are driven 0.
//   - The FIFO is not popped and underrun is not set.
//  enable 0->1: the first slot start (left) happens on the same edge that samples enable=1.
//  enable 1->0 mid-frame: the frame is abandoned immediately; the partially sent sample is lost.
//  clear and underrun-set in the same cycle: set wins.
//  reset_n asserted mid-operation: immediate return to reset values; FIFO contents are discarded.
// CONFIGURATION
//  AUDIO_SERIAL_TX_I2S_EN defined:
//   - I2S framing: sdata lags lrclk by one bit period.
//   - Bit 0 of each slot carries the LSB of the previous slot's sample.
//   - The MSB appears at bit 1. The first slot after enable/reset sends 0 at bit 0.
//  AUDIO_SERIAL_TX_I2S_EN undefined: left-justified framing; the MSB coincides with the lrclk transition.
//  Pop timing and the underrun rule are identical in both modes.
// TESTING
//  All scenarios use defaults (WIDTH=32, DEPTH=4, BCLK_DIV=4): 128 clocks per slot, 256 per frame.
//  1. Reset, enable=1, push 32'h80000001 then 32'h7FFFFFFE
//     -> left slot bits "1000..0001", right slot "0111..1110"; lrclk 0 then 1; underrun stays 0.
//  2. Push 4 samples with enable=0 -> ready=0 after the 4th; a 5th valid is not accepted;
//     after enable=1 the 4 samples are serialized in order L,R,L,R.
//  3. enable=1 with an empty FIFO -> sdata=0 for the whole frame; underrun=1 from clock 1;
//     clear=1 -> underrun back to 0 unless a new slot start occurs in the same cycle.
//  4. bclk check: over one frame, bclk has 64 rising edges, a period of 4 clocks and a duty of 2/2;
//     sdata stable between falling edges.
//  5. Assert reset_n mid-slot (clock 60) with 2 samples queued -> all outputs return to reset values
//     asynchronously; after release the FIFO is empty and ready=1.
//  6. With AUDIO_SERIAL_TX_I2S_EN, push 32'hC0000000, 32'h00000001 -> left slot bit 0 = 0,
//     bits 1-2 = 1; right slot bit 0 = 0 (left LSB), right LSB appears at bit 0 of the next left slot.

Source files
------------

// File: rtl/audio_serial_tx.sv
// rtl/audio_serial_tx.sv - FIFO-buffered stereo bit-serial audio transmitter (left-justified; I2S when AUDIO_SERIAL_TX_I2S_EN is defined)
module audio_serial_tx #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int BCLK_DIV = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] audio,
    input  logic             valid,
    output logic             ready,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun,
    input  logic             clear
);

`ifdef AUDIO_SERIAL_TX_I2S_EN
    localparam bit I2S_EN = 1'b1;
`else
    localparam bit I2S_EN = 1'b0;
`endif

    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int BW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [DW-1:0]    div_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             slot;
    logic [WIDTH-1:0] shift;
    logic             prev_bit;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bit_start;
    logic             slot_start;
    logic             next_bit;
    logic [WIDTH-1:0] head;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ready      = !full;
    assign push       = valid && !full;
    assign bit_start  = enable && (div_cnt == '0);
    assign slot_start = bit_start && (bit_cnt == '0);
    assign pop        = slot_start && !empty;
    // An empty FIFO at slot start sends a silent (all-zero) word.
    assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign next_bit   = slot_start ? head[WIDTH-1] : shift[WIDTH-1];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= audio;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // prev_bit delays the stream by one bit period for I2S framing.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            slot     <= 1'b0;
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            shift    <= '0;
            prev_bit <= 1'b0;
        end else if (!enable) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            slot     <= 1'b0;
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            shift    <= '0;
            prev_bit <= 1'b0;
        end else begin
            bclk <= (div_cnt >= DIV_HALF);
            if (bit_start) begin
                lrclk    <= slot;
                sdata    <= I2S_EN ? prev_bit : next_bit;
                prev_bit <= next_bit;
                shift    <= slot_start ? {head[WIDTH-2:0], 1'b0} : {shift[WIDTH-2:0], 1'b0};
            end
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt <= '0;
                    slot    <= ~slot;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            underrun <= 1'b0;
        end else if (slot_start && empty) begin
            underrun <= 1'b1;
        end else if (clear) begin
            underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_serial_tx.sv
// tb/tb_audio_serial_tx.sv - scoreboard bench for audio_serial_tx with a queue-based reference model
module tb_audio_serial_tx;

    localparam int W    = 32;
    localparam int D    = 4;
    localparam int BD   = 4;
    localparam int SLOT = W * BD;
`ifdef AUDIO_SERIAL_TX_I2S_EN
    localparam bit I2S = 1'b1;
`else
    localparam bit I2S = 1'b0;
`endif

    logic         clock;
    logic         reset_n;
    logic         enable;
    logic [W-1:0] audio;
    logic         valid;
    logic         ready;
    logic         bclk;
    logic         lrclk;
    logic         sdata;
    logic         underrun;
    logic         clear;

    audio_serial_tx #(.WIDTH(W), .DEPTH(D), .BCLK_DIV(BD)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .enable   (enable),
        .audio    (audio),
        .valid    (valid),
        .ready    (ready),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .underrun (underrun),
        .clear    (clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample FIFO as a queue, slot words pushed to the scoreboard at slot start.
    logic [W-1:0] mq[$];
    logic [W-1:0] exp_q[$];
    int  k  = 0;
    int  kp = 0;
    bit  en_q  = 1'b0;
    bit  m_und = 1'b0;
    bit  was_full;
    bit  set_u;

    always @(posedge clock) begin
        if (!reset_n) begin
            mq.delete();
            exp_q.delete();
            k = 0; kp = 0; en_q = 1'b0; m_und = 1'b0;
        end else begin
            was_full = (mq.size() == D);
            set_u    = 1'b0;
            en_q     = enable;
            kp       = k;
            if (enable) begin
                if (k % SLOT == 0) begin
                    if (mq.size() > 0) exp_q.push_back(mq.pop_front());
                    else begin
                        exp_q.push_back('0);
                        set_u = 1'b1;
                    end
                end
                k++;
            end else begin
                k = 0;
            end
            if (set_u) m_und = 1'b1;
            else if (clear) m_und = 1'b0;
            if (valid && !was_full) mq.push_back(audio);
        end
    end

    // Monitor: rebuilds each slot word from sdata and pops the scoreboard when a slot completes.
    logic [W-1:0] word;
    bit  have = 1'b0;
    logic last_sd;
    int  ph, bp, b, s;

    task automatic cmp_slot();
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL slot_word actual=%h expected=<none> t=%0t", word, $time);
        end else begin
            chk("slot_word", word, exp_q.pop_front());
        end
        have = 1'b0;
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_bclk", bclk, 0);
            chk("rst_lrclk", lrclk, 0);
            chk("rst_sdata", sdata, 0);
            chk("rst_underrun", underrun, 0);
            chk("rst_ready", ready, 1);
            have = 1'b0;
        end else begin
            chk("ready", ready, mq.size() < D);
            chk("underrun", underrun, m_und);
            if (!en_q) begin
                chk("idle_bclk", bclk, 0);
                chk("idle_lrclk", lrclk, 0);
                chk("idle_sdata", sdata, 0);
                if (have) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    have = 1'b0;
                end
            end else begin
                ph = kp % BD;
                bp = kp / BD;
                b  = bp % W;
                s  = (bp / W) % 2;
                chk("bclk", bclk, ph >= BD / 2);
                chk("lrclk", lrclk, s);
                if (ph == 0) begin
                    last_sd = sdata;
                    if (I2S) begin
                        if (b == 0) begin
                            if (have) begin
                                word[0] = sdata;
                                cmp_slot();
                            end else begin
                                chk("i2s_first_bit0", sdata, 0);
                            end
                            word = '0;
                            have = 1'b1;
                        end else begin
                            word[W-b] = sdata;
                        end
                    end else begin
                        if (b == 0) begin
                            word = '0;
                            have = 1'b1;
                        end
                        word[W-1-b] = sdata;
                        if (b == W - 1) cmp_slot();
                    end
                end else begin
                    chk("sdata_stable", sdata, last_sd);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic [W-1:0] w);
        valid = 1'b1;
        audio = w;
        cyc(1);
        valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; valid = 1'b0; clear = 1'b0; audio = '0;
        cyc(3);
        reset_n = 1'b1;

        // Directed words, left then right, no underrun inside the frame.
        push(32'h80000001);
        push(32'h7FFFFFFE);
        enable = 1'b1;
        cyc(2 * SLOT);
        enable = 1'b0;
        chk("s1_underrun", underrun, 0);
        cyc(2);

        // I2S-oriented words; the following underrun slot exposes the trailing LSB.
        push(32'hC0000000);
        push(32'h00000001);
        enable = 1'b1;
        cyc(2 * SLOT + 2 * BD);
        enable = 1'b0;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("s6_cleared", underrun, 0);

        // Fill the FIFO while idle; a fifth valid must be refused.
        for (int i = 0; i < 4; i++) push($urandom);
        chk("s2_ready_full", ready, 0);
        push(32'hDEADBEEF);
        enable = 1'b1;
        cyc(4 * SLOT);
        enable = 1'b0;
        cyc(2);

        // Empty FIFO: underrun from clock 1, clear held across a slot start.
        enable = 1'b1;
        cyc(2);
        chk("s3_underrun_clk1", underrun, 1);
        clear = 1'b1;
        cyc(SLOT + 10);
        clear = 1'b0;
        enable = 1'b0;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("s3_clear", underrun, 0);

        // Asynchronous reset mid-slot with samples still queued.
        push(32'h11111111);
        push(32'h22222222);
        push(32'h33333333);
        enable = 1'b1;
        cyc(60);
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("s5_async_bclk", bclk, 0);
        chk("s5_async_lrclk", lrclk, 0);
        chk("s5_async_sdata", sdata, 0);
        chk("s5_async_ready", ready, 1);
        enable = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        chk("s5_ready_after", ready, 1);
        push(32'hA5A5A5A5);
        enable = 1'b1;
        cyc(SLOT + BD);
        enable = 1'b0;
        cyc(2);

        // Randomized traffic with occasional enable toggles and clears.
        enable = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            valid = ($urandom % 3) == 0;
            audio = $urandom;
            clear = ($urandom % 50) == 0;
            if (($urandom % 700) == 0) enable = ~enable;
            cyc(1);
        end
        valid = 1'b0;
        clear = 1'b0;
        enable = 1'b0;
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
